// File: rtl/rst_seq_monitor.sv
// rst_seq_monitor
//   Watches the five staged reset/enable lines of the pipeline and checks that
//   they are released in the order mem, pe, 3b3, 2b2, disp, with at least
//   MIN_DWELL cycles between consecutive releases. A legal release advances the
//   phase and pulses the matching start_* output. An illegal event parks the
//   block in PERR and records the first cause.
//
// Ports
//   clk                      system clock, rising edge
//   rst                      asynchronous active-low reset
//   rst_mem/pe/3b3/2b2       stage resets, high = held
//   rst_disp                 display enable, low = held
//   start_*                  one-cycle pulse on legal release of that stage
//   phase                    0..5 = P0..P5, 7 = PERR
//   dwell_cnt                cycles spent in the current phase (saturating)
//   last_dwell               dwell of the most recently completed phase
//   all_done                 high while in P5
//   seq_err                  sticky error flag
//   err_code                 first cause: 1 too soon, 2 out of order, 3 re-assert
module rst_seq_monitor #(
  parameter int unsigned MIN_DWELL = 20,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_mem,
  input  logic             rst_pe,
  input  logic             rst_3b3,
  input  logic             rst_2b2,
  input  logic             rst_disp,
  output logic             start_mem,
  output logic             start_pe,
  output logic             start_3b3,
  output logic             start_2b2,
  output logic             start_disp,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic [CNT_W-1:0] last_dwell,
  output logic             all_done,
  output logic             seq_err,
  output logic [1:0]       err_code
);

  typedef enum logic [2:0] {
    P0   = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    P4   = 3'd4,
    P5   = 3'd5,
    PERR = 3'd7
  } phase_t;

  // Capture register bit order: {disp, 2b2, 3b3, pe, mem}; all-held value.
  localparam logic [4:0]       CAP_HELD    = 5'b01111;
  localparam logic [CNT_W-1:0] MIN_DWELL_C = CNT_W'(MIN_DWELL);

  phase_t     state;
  phase_t     nxt_state;
  phase_t     adv_state;
  logic [4:0] cap;
  logic [4:0] rel;
  logic [4:0] exp_mask;
  logic [4:0] nxt_bit;
  logic [4:0] early;
  logic [4:0] start_q;
  logic [4:0] start_nxt;
  logic [1:0] cause;
  logic       chg;

  // Released flags in release order, bit 0 = mem ... bit 4 = disp.
  assign rel = {cap[4], ~cap[3:0]};

  // exp_mask holds the stages that must already be released in this phase;
  // anything released beyond it is either the single legal next stage or an
  // ordering error. Checks run from highest to lowest priority so the first
  // matching cause wins.
  always_comb begin
    exp_mask  = '0;
    nxt_bit   = '0;
    adv_state = PERR;
    case (state)
      P0: begin exp_mask = 5'b00000; nxt_bit = 5'b00001; adv_state = P1; end
      P1: begin exp_mask = 5'b00001; nxt_bit = 5'b00010; adv_state = P2; end
      P2: begin exp_mask = 5'b00011; nxt_bit = 5'b00100; adv_state = P3; end
      P3: begin exp_mask = 5'b00111; nxt_bit = 5'b01000; adv_state = P4; end
      P4: begin exp_mask = 5'b01111; nxt_bit = 5'b10000; adv_state = P5; end
      P5: begin exp_mask = 5'b11111; nxt_bit = 5'b00000; adv_state = P5; end
      default: ;
    endcase

    early     = rel & ~exp_mask;
    cause     = 2'd0;
    nxt_state = state;
    start_nxt = '0;
    chg       = 1'b0;

    if (state == PERR) begin
      if (rel == '0) begin
        nxt_state = P0;
        chg       = 1'b1;
      end
    end else if ((exp_mask & ~rel) != '0) begin
      cause = 2'd3;
    end else if ((early != '0) && (early != nxt_bit)) begin
      cause = 2'd2;
    end else if (early != '0) begin
      if ((state != P0) && (dwell_cnt < MIN_DWELL_C)) begin
        cause = 2'd1;
      end else begin
        nxt_state = adv_state;
        start_nxt = nxt_bit;
        chg       = 1'b1;
      end
    end

    if (cause != 2'd0) begin
      nxt_state = PERR;
      chg       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= P0;
      cap        <= CAP_HELD;
      start_q    <= '0;
      dwell_cnt  <= '0;
      last_dwell <= '0;
      all_done   <= 1'b0;
      seq_err    <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      cap      <= {rst_disp, rst_2b2, rst_3b3, rst_pe, rst_mem};
      state    <= nxt_state;
      start_q  <= start_nxt;
      all_done <= (nxt_state == P5);

      if (chg) begin
        last_dwell <= dwell_cnt;
        dwell_cnt  <= CNT_W'(1);
      end else if (dwell_cnt != '1) begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end

      if (cause != 2'd0) begin
        seq_err <= 1'b1;
        if (err_code == 2'd0) begin
          err_code <= cause;
        end
      end
    end
  end

  assign phase      = state;
  assign start_mem  = start_q[0];
  assign start_pe   = start_q[1];
  assign start_3b3  = start_q[2];
  assign start_2b2  = start_q[3];
  assign start_disp = start_q[4];

endmodule
